// File: rtl/mem_req_ctrl.sv
`timescale 1ns/1ps
// mem_req_ctrl
// Memory-stage request controller between the pipeline memory stage and a
// stalling data memory. One load/store is in flight at a time. The command is
// held stable on the memory port until mem_done. The read data is captured,
// and the access completes with a one-cycle response pulse carrying an error
// status. Misaligned (odd) addresses are rejected locally without any memory
// access. stall_cnt saturates and counts BUSY cycles with mem_stall high.
//
// Optional feature, macro MEM_TIMEOUT_EN:
//   defined     - the access is aborted after TIMEOUT_CYCLES BUSY cycles
//                 without mem_done. The response then has resp_err and
//                 resp_timeout set.
//   not defined - BUSY waits indefinitely for mem_done and resp_timeout is 0.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   req_valid/wr/addr/wdata   pipeline request
//   req_ready, pipe_stall     accept / stall handshake
//   resp_valid/rdata/err/timeout  one-cycle completion
//   mem_rd/wr/addr/wdata      memory command, driven only in BUSY
//   mem_dataout/done/stall/err  memory status
//   stall_cnt, stall_cnt_clr  saturating memory-stall cycle counter
//
// state | meaning
// IDLE  | no access in flight, ready for a request
// BUSY  | command on the memory port, waiting for mem_done
// RESP  | response pulse this cycle, a new request may be accepted

module mem_req_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        pipe_stall,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        resp_err,
    output logic        resp_timeout,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_dataout,
    input  logic        mem_done,
    input  logic        mem_stall,
    input  logic        mem_err,
    output logic [15:0] stall_cnt,
    input  logic        stall_cnt_clr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   accept;
    logic   tmo_hit;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("mem_req_ctrl: TIMEOUT_CYCLES out of range 1..65535");
    end

    assign req_ready  = (state == IDLE) | (state == RESP);
    assign pipe_stall = req_valid & ~req_ready;
    assign accept     = req_valid & req_ready;

`ifdef MEM_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    // The counter holds the number of completed BUSY cycles without done.
    // Therefore expiry is the last BUSY cycle, when the counter is one short.
    assign tmo_hit = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // The mem_* registers also act as the request hold registers. They are
    // loaded on an aligned accept and cleared on every exit from BUSY.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            resp_valid   <= 1'b0;
            resp_rdata   <= 16'h0000;
            resp_err     <= 1'b0;
            resp_timeout <= 1'b0;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_addr     <= 16'h0000;
            mem_wdata    <= 16'h0000;
            stall_cnt    <= 16'h0000;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt      <= 16'h0000;
`endif
        end else begin
            resp_valid   <= 1'b0;
            resp_rdata   <= 16'h0000;
            resp_err     <= 1'b0;
            resp_timeout <= 1'b0;

            if (stall_cnt_clr) begin
                stall_cnt <= 16'h0000;
            end else if (state == BUSY && mem_stall && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end

            case (state)
                IDLE, RESP: begin
                    if (accept) begin
`ifdef MEM_TIMEOUT_EN
                        tmo_cnt <= 16'h0000;
`endif
                        if (req_addr[0]) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            state     <= BUSY;
                            mem_rd    <= ~req_wr;
                            mem_wr    <= req_wr;
                            mem_addr  <= req_addr;
                            mem_wdata <= req_wdata;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (mem_done || tmo_hit) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        mem_rd     <= 1'b0;
                        mem_wr     <= 1'b0;
                        mem_addr   <= 16'h0000;
                        mem_wdata  <= 16'h0000;
                        if (mem_done) begin
                            resp_err   <= mem_err;
                            resp_rdata <= (mem_wr | mem_err) ? 16'h0000 : mem_dataout;
                        end else begin
                            resp_err     <= 1'b1;
                            resp_timeout <= 1'b1;
                        end
                    end
`ifdef MEM_TIMEOUT_EN
                    else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_ctrl.sv
`timescale 1ns/1ps
module tb_mem_req_ctrl;

`ifdef MEM_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif
    localparam int T_CYC = 4;

    logic        clk, rst_n;
    logic        req_valid, req_wr;
    logic [15:0] req_addr, req_wdata;
    logic        req_ready, pipe_stall;
    logic        resp_valid, resp_err, resp_timeout;
    logic [15:0] resp_rdata;
    logic        mem_rd, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_dataout;
    logic        mem_done, mem_stall, mem_err;
    logic [15:0] stall_cnt;
    logic        stall_cnt_clr;

    mem_req_ctrl #(.TIMEOUT_CYCLES(T_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .pipe_stall(pipe_stall),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .resp_timeout(resp_timeout),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_dataout(mem_dataout), .mem_done(mem_done), .mem_stall(mem_stall),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .stall_cnt_clr(stall_cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          lat;      // cycles from accept edge to the resp_valid cycle
        logic [15:0] rd;
        logic        err;
        logic        to;
        int          nbusy;    // cycles the command was on the memory port
        logic        stable;
    } res_t;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          ns;       // stall cycles before done
        int          nw;       // extra non-stall wait cycles before done
        logic        merr;
        int          e_lat;
        logic [15:0] e_rd;
        logic        e_err;
        int          e_busy;
        int          e_sd;     // stall_cnt increment
    } vec_t;

    logic [15:0] mem_img [int];   // contents the bench memory serves
    logic [15:0] ref_img [int];   // reference model's view of memory
    int          stall_exp;

    function automatic logic [15:0] mem_default(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    // Reference: outcome of one request from the rules of the controller,
    // given how many stall/wait cycles the memory inserts before done.
    function automatic void ref_txn(input logic wr, input logic [15:0] addr,
                                    input logic [15:0] wdata, input int ns, input int nw,
                                    input logic merr, output res_t e, output int sd);
        int need;
        e.stable = 1'b1;
        e.to = 1'b0;
        if (addr[0]) begin
            e.lat = 1; e.rd = 16'h0; e.err = 1'b1; e.nbusy = 0; sd = 0;
            return;
        end
        need = ns + nw + 1;
        if (TMO_ON && need > T_CYC) begin
            e.lat = 1 + T_CYC; e.rd = 16'h0; e.err = 1'b1; e.to = 1'b1;
            e.nbusy = T_CYC; sd = (ns < T_CYC) ? ns : T_CYC;
            return;
        end
        e.lat = 1 + need; e.err = merr; e.nbusy = need; sd = ns;
        if (wr || merr) e.rd = 16'h0;
        else e.rd = ref_img.exists(addr) ? ref_img[addr] : mem_default(addr);
        if (wr && !merr) ref_img[addr] = wdata;
    endfunction

    // Issue one request and play the memory side until the response.
    task automatic exec(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                        input int ns, input int nw, input logic merr, input int max_cyc,
                        output res_t r);
        int w;
        r.lat = 1; r.nbusy = 0; r.stable = 1'b1; r.rd = 'x; r.err = 1'bx; r.to = 1'bx;
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
        w = 0;
        while (!req_ready && w < 10) begin
            @(posedge clk); #1; w++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
        while (r.lat <= max_cyc) begin
            mem_done = 1'b0; mem_stall = 1'b0; mem_err = 1'b0; mem_dataout = 16'h0;
            if (resp_valid) begin
                r.rd = resp_rdata; r.err = resp_err; r.to = resp_timeout;
                break;
            end
            if (mem_rd || mem_wr) begin
                r.nbusy++;
                if (mem_wr !== wr || mem_rd !== ~wr || mem_addr !== addr || mem_wdata !== wdata)
                    r.stable = 1'b0;
                if (r.nbusy <= ns) begin
                    mem_stall = 1'b1;
                end else if (r.nbusy > ns + nw) begin
                    mem_done = 1'b1;
                    mem_err = merr;
                    if (!wr) begin
                        mem_dataout = mem_img.exists(addr) ? mem_img[addr] : mem_default(addr);
                    end else begin
                        mem_dataout = 16'($urandom);
                        if (!merr) mem_img[addr] = wdata;
                    end
                end
            end
            @(posedge clk); #1;
            r.lat++;
        end
        mem_done = 1'b0; mem_stall = 1'b0; mem_err = 1'b0; mem_dataout = 16'h0;
        if (r.lat > max_cyc) begin
            n_cmp++; n_bad++;
            $display("FAIL resp_wait: no resp_valid within %0d cycles", max_cyc);
        end
    endtask

    task automatic check_res(input string tag, input res_t a, input res_t e, input int sd);
        chk({tag, ".lat"}, a.lat, e.lat);
        chk({tag, ".rdata"}, a.rd, e.rd);
        chk({tag, ".err"}, a.err, e.err);
        chk({tag, ".timeout"}, a.to, e.to);
        chk({tag, ".busy_cycles"}, a.nbusy, e.nbusy);
        chk({tag, ".cmd_stable"}, a.stable, 1'b1);
        stall_exp = (stall_exp + sd > 65535) ? 65535 : stall_exp + sd;
        chk({tag, ".stall_cnt"}, stall_cnt, stall_exp);
        @(posedge clk); #1;
        chk({tag, ".resp_one_cycle"}, resp_valid, 1'b0);
    endtask

    vec_t tbl[7];

    initial begin
        res_t r, e;
        int   sd;

        tbl[0] = '{wr:1'b0, addr:16'h0010, wdata:16'h0000, ns:0, nw:0, merr:1'b0,
                   e_lat:2, e_rd:16'hBEEF, e_err:1'b0, e_busy:1, e_sd:0};
        tbl[1] = '{wr:1'b1, addr:16'h0020, wdata:16'h1234, ns:3, nw:0, merr:1'b0,
                   e_lat:5, e_rd:16'h0000, e_err:1'b0, e_busy:4, e_sd:3};
        tbl[2] = '{wr:1'b0, addr:16'h0021, wdata:16'h0000, ns:0, nw:0, merr:1'b0,
                   e_lat:1, e_rd:16'h0000, e_err:1'b1, e_busy:0, e_sd:0};
        tbl[3] = '{wr:1'b0, addr:16'h0020, wdata:16'h0000, ns:0, nw:1, merr:1'b0,
                   e_lat:3, e_rd:16'h1234, e_err:1'b0, e_busy:2, e_sd:0};
        tbl[4] = '{wr:1'b0, addr:16'h0030, wdata:16'h0000, ns:0, nw:0, merr:1'b1,
                   e_lat:2, e_rd:16'h0000, e_err:1'b1, e_busy:1, e_sd:0};
        tbl[5] = '{wr:1'b1, addr:16'h0041, wdata:16'h9999, ns:0, nw:0, merr:1'b0,
                   e_lat:1, e_rd:16'h0000, e_err:1'b1, e_busy:0, e_sd:0};
        tbl[6] = '{wr:1'b0, addr:16'h0012, wdata:16'h0000, ns:2, nw:1, merr:1'b0,
                   e_lat:5, e_rd:16'hA5D1, e_err:1'b0, e_busy:4, e_sd:2};

        mem_img[16'h0010] = 16'hBEEF; ref_img[16'h0010] = 16'hBEEF;
        mem_img[16'h0030] = 16'h5555; ref_img[16'h0030] = 16'h5555;
        mem_img[16'h0040] = 16'hC0DE;
        mem_img[16'h0042] = 16'hF00D;

        rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
        mem_dataout = 16'h0; mem_done = 1'b0; mem_stall = 1'b0; mem_err = 1'b0;
        stall_cnt_clr = 1'b0; stall_exp = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.req_ready", req_ready, 1'b1);
        chk("reset.resp_valid", resp_valid, 1'b0);
        chk("reset.mem_cmd", {mem_rd, mem_wr, mem_addr, mem_wdata}, 34'h0);
        chk("reset.stall_cnt", stall_cnt, 16'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // directed vectors
        for (int i = 0; i < 7; i++) begin
            ref_txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].ns, tbl[i].nw, tbl[i].merr, e, sd);
            exec(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].ns, tbl[i].nw, tbl[i].merr, 50, r);
            e.lat = tbl[i].e_lat; e.rd = tbl[i].e_rd; e.err = tbl[i].e_err;
            e.to = 1'b0; e.nbusy = tbl[i].e_busy;
            check_res($sformatf("vec%0d", i), r, e, tbl[i].e_sd);
        end

        // back-to-back loads with req_valid held high
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0040; req_wdata = 16'h0;
        @(posedge clk); #1;
        req_addr = 16'h0042;
        chk("b2b.pipe_stall_busy", pipe_stall, 1'b1);
        chk("b2b.mem1", {mem_rd, mem_addr}, {1'b1, 16'h0040});
        mem_done = 1'b1; mem_dataout = 16'hC0DE;
        @(posedge clk); #1;
        mem_done = 1'b0; mem_dataout = 16'h0;
        chk("b2b.resp1", {resp_valid, resp_rdata}, {1'b1, 16'hC0DE});
        chk("b2b.ready_in_resp", {req_ready, pipe_stall}, 2'b10);
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = 16'h0;
        chk("b2b.gap", resp_valid, 1'b0);
        chk("b2b.mem2", {mem_rd, mem_addr}, {1'b1, 16'h0042});
        mem_done = 1'b1; mem_dataout = 16'hF00D;
        @(posedge clk); #1;
        mem_done = 1'b0; mem_dataout = 16'h0;
        chk("b2b.resp2", {resp_valid, resp_rdata}, {1'b1, 16'hF00D});
        @(posedge clk); #1;

        // watchdog behaviour at its boundary
`ifdef MEM_TIMEOUT_EN
        exec(1'b0, 16'h0060, 16'h0, 0, 1000, 1'b0, 50, r);
        e = '{lat:5, rd:16'h0, err:1'b1, to:1'b1, nbusy:4, stable:1'b1};
        check_res("tmo_abort", r, e, 0);
        exec(1'b0, 16'h0060, 16'h0, 0, 3, 1'b0, 50, r);
        e = '{lat:5, rd:16'hA5A3, err:1'b0, to:1'b0, nbusy:4, stable:1'b1};
        check_res("tmo_done_same_cycle", r, e, 0);
`else
        exec(1'b0, 16'h0060, 16'h0, 0, 20, 1'b0, 50, r);
        e = '{lat:22, rd:16'hA5A3, err:1'b0, to:1'b0, nbusy:21, stable:1'b1};
        check_res("no_tmo_long_wait", r, e, 0);
`endif

        // randomized requests against the reference model
        for (int i = 0; i < 40; i++) begin
            logic        wr, mis, merr;
            logic [15:0] addr, wdata;
            int          ns, nw;
            wr    = 1'($urandom);
            mis   = ($urandom_range(0, 7) == 0);
            merr  = ($urandom_range(0, 7) == 0);
            addr  = 16'h0100 + 16'($urandom_range(0, 7) * 2) + {15'h0, mis};
            wdata = 16'($urandom);
            ns    = $urandom_range(0, 3);
            nw    = $urandom_range(0, 2);
            ref_txn(wr, addr, wdata, ns, nw, merr, e, sd);
            exec(wr, addr, wdata, ns, nw, merr, 50, r);
            check_res($sformatf("rnd%0d", i), r, e, sd);
        end

        // reset in the middle of BUSY, with a store completing in that cycle
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0050; req_wdata = 16'h7777;
        @(posedge clk); #1;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
        chk("rst_busy.mem_wr", mem_wr, 1'b1);
        mem_done = 1'b1; mem_stall = 1'b1; rst_n = 1'b0;
        @(posedge clk); #1;
        mem_done = 1'b0; mem_stall = 1'b0; rst_n = 1'b1;
        chk("rst_busy.idle", {req_ready, pipe_stall}, 2'b10);
        chk("rst_busy.resp", {resp_valid, resp_err, resp_timeout, resp_rdata}, 19'h0);
        chk("rst_busy.mem_cmd", {mem_rd, mem_wr, mem_addr, mem_wdata}, 34'h0);
        chk("rst_busy.stall_cnt", stall_cnt, 16'h0);
        stall_exp = 0;
        @(posedge clk); #1;
        chk("rst_busy.no_resp", resp_valid, 1'b0);

`ifndef MEM_TIMEOUT_EN
        // saturation of stall_cnt, then clear
        exec(1'b0, 16'h0010, 16'h0, 65540, 0, 1'b0, 70000, r);
        e = '{lat:65542, rd:16'hBEEF, err:1'b0, to:1'b0, nbusy:65541, stable:1'b1};
        check_res("sat_fill", r, e, 65540);
        exec(1'b0, 16'h0010, 16'h0, 2, 0, 1'b0, 50, r);
        e = '{lat:4, rd:16'hBEEF, err:1'b0, to:1'b0, nbusy:3, stable:1'b1};
        check_res("sat_hold", r, e, 2);
`endif
        stall_cnt_clr = 1'b1;
        @(posedge clk); #1;
        stall_cnt_clr = 1'b0;
        chk("stall_clr", stall_cnt, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_req_ctrl.md
# mem_req_ctrl

Memory-stage request controller between the pipeline's memory stage and the stalling data memory. Accepts one load/store at a time from the pipeline, holds address/data/command stable on the memory port until the memory reports done, captures the read data, and returns a one-cycle response with error status. Generates the pipeline stall, rejects misaligned accesses locally, and keeps a saturating count of memory stall cycles.

## Interface
- `TIMEOUT_CYCLES`, 64: BUSY cycles without `mem_done` before abort (only with `MEM_TIMEOUT_EN`); legal range 1..65535.
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req_valid`  in  1  pipeline request present.
- `req_wr`  in  1  1 = store, 0 = load.
- `req_addr`  in  16  byte address.
- `req_wdata`  in  16  store data.
- `req_ready`  out  1  controller can accept this cycle.
- `pipe_stall`  out  1  = `req_valid & ~req_ready`.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  16  load data, valid with `resp_valid`; 0 for stores and errors.
- `resp_err`  out  1  misaligned, memory error, or timeout.
- `resp_timeout`  out  1  completion was a watchdog abort.
- `mem_rd`, `mem_wr`  out  1 each  memory command.
- `mem_addr`, `mem_wdata`  out  16 each  memory address/data.
- `mem_dataout`  in  16  memory read data (combinational in the done cycle).
- `mem_done`, `mem_stall`, `mem_err`  in  1 each  memory status.
- `stall_cnt`  out  16  saturating count of BUSY cycles with `mem_stall=1`.
- `stall_cnt_clr`  in  1  synchronous clear of `stall_cnt`.

## Operation
- States: IDLE, BUSY, RESP. `req_ready = (state==IDLE) | (state==RESP)`.
- Accept (req_valid & req_ready): latch `req_wr/addr/wdata` into hold registers, clear timeout counter.
  - `req_addr[0]==1`: no memory access; next state RESP with `resp_err=1`, `resp_rdata=0`.
  - Otherwise next state BUSY.
- No accept: IDLE stays IDLE; RESP returns to IDLE.
- BUSY: `mem_rd = ~hold_wr`, `mem_wr = hold_wr`, `mem_addr/mem_wdata` = hold regs, stable every cycle until exit.
  - `mem_done=1`: capture `mem_dataout` (loads; 0 for stores) and `mem_err` into response regs; next RESP.
  - `mem_done=0`: stay BUSY; timeout counter +1.
- RESP: `resp_valid=1` for exactly one cycle; response regs drive `resp_*`.
- Outside BUSY: `mem_rd=mem_wr=0`, `mem_addr=mem_wdata=0`.
- `stall_cnt`: +1 each cycle in BUSY with `mem_stall=1`; saturates at 16'hFFFF; `stall_cnt_clr` has priority over increment.
- `req_valid` while not ready is ignored; the pipeline holds it (via `pipe_stall`).

## Timing
- Reset (rst_n low at an edge): state IDLE, all outputs 0, hold/response regs 0, timeout counter 0, `stall_cnt` 0. Reset mid-BUSY abandons the access; a write the memory completed in that same cycle is not reported.
- Aligned access accepted at edge N: BUSY from N+1; if `mem_done` is seen in cycle N+1+k, `resp_valid` is high in cycle N+2+k. Minimum accept-to-response is 2 cycles.
- Misaligned: `resp_valid` high in the cycle after accept, no `mem_rd/mem_wr` pulse.
- Back-to-back: a request accepted during RESP enters BUSY on the next edge; sustained throughput is one access per 2 cycles with zero memory stall.
- `mem_err` is sampled only with `mem_done`.

## Configuration
- `MEM_TIMEOUT_EN` defined: in BUSY, when the timeout counter reaches `TIMEOUT_CYCLES` without `mem_done`, drop the command, go RESP with `resp_err=1`, `resp_timeout=1`, `resp_rdata=0`. `mem_done` in the same cycle as expiry wins (normal completion).
- Not defined: no timeout counter; BUSY waits indefinitely; `resp_timeout` tied 0.

## Test plan
- Load 0x0010, memory holds 0xBEEF, `mem_done` on first BUSY cycle -> `resp_valid` 2 cycles after accept, `resp_rdata=0xBEEF`, `resp_err=0`.
- Store 0x1234 to 0x0020, `mem_stall` 3 cycles then done -> `mem_wr`/addr/data stable 4 cycles, `resp_valid` 5 cycles after accept, `stall_cnt=3`.
- Load 0x0021 -> no `mem_rd`, `resp_valid` next cycle, `resp_err=1`, `resp_rdata=0`.
- Two loads back-to-back (second `req_valid` held high) -> second accepted in first's RESP cycle; responses 2 cycles apart; `pipe_stall` high during first BUSY.
- `MEM_TIMEOUT_EN`, `TIMEOUT_CYCLES=4`, memory never done -> abort after 4 BUSY cycles, `resp_err=1`, `resp_timeout=1`; repeat with done on the 4th BUSY cycle -> normal completion.
- `rst_n` low during BUSY -> next cycle all outputs 0, state IDLE; `stall_cnt` at 0xFFFF stays 0xFFFF on further stalls, returns to 0 on `stall_cnt_clr`.
